// File: rtl/counter_hex_input.sv
// Debounced push-button hex counter: synchronizes and filters a bouncing key,
// steps a 4-bit count once per accepted press, with load and wrap reporting.
//
// state        | meaning
// RELEASED     | key idle, waiting for a synchronized low
// PRESS_WAIT   | low seen, waiting for the debouncer to accept the press
// PRESSED      | press accepted (step issued), waiting for a synchronized high
// RELEASE_WAIT | high seen, waiting for the debouncer to accept the release
module counter_hex_input #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [3:0] RESET_VALUE     = 4'h0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_key_n,
  input  logic       i_down,
  input  logic       i_load,
  input  logic [3:0] i_load_value,
  output logic [3:0] o_count,
  output logic       o_step,
  output logic       o_wrap
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic          sync1_q, sync2_q;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic          step_go;
  logic [3:0]    count_q, count_d;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;

  // Synchronizer idles high so a key held through reset still reads as a fresh press.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_key_n;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    if (sync2_q != acc_q) begin
      if (cnt_q == CNT_LAST) acc_d = ~acc_q;
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  // Acceptance wins over a late bounce in the same cycle: the press still counts.
  always_comb begin
    state_d = state_q;
    step_go = 1'b0;
    case (state_q)
      RELEASED:     if (!sync2_q) state_d = PRESS_WAIT;
      PRESS_WAIT: begin
        if (!acc_q) begin
          state_d = PRESSED;
          step_go = 1'b1;
        end else if (sync2_q) begin
          state_d = RELEASED;
        end
      end
      PRESSED:      if (sync2_q) state_d = RELEASE_WAIT;
      RELEASE_WAIT: begin
        if (acc_q)         state_d = RELEASED;
        else if (!sync2_q) state_d = PRESSED;
      end
      default:      state_d = RELEASED;
    endcase
  end

  // A load swallows a coincident step entirely.
  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (i_load) begin
      count_d = i_load_value;
    end else if (step_go) begin
      step_d = 1'b1;
      if (i_down) begin
        count_d = count_q - 4'd1;
        wrap_d  = (count_q == 4'h0);
      end else begin
        count_d = count_q + 4'd1;
        wrap_d  = (count_q == 4'hF);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      state_q <= RELEASED;
      count_q <= RESET_VALUE;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      count_q <= count_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_count = count_q;
  assign o_step  = step_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_counter_hex_input.sv
// Scoreboard bench for counter_hex_input with DEBOUNCE_CYCLES = 4: stimulus queues
// expected output events, a monitor pops them whenever the outputs show activity.
module tb_counter_hex_input;

  logic       clk = 1'b0;
  logic       i_reset, i_key_n, i_down, i_load;
  logic [3:0] i_load_value;
  logic [3:0] o_count;
  logic       o_step, o_wrap;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
    logic       step;
    logic       wrap;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  logic [3:0] prev_cnt = 4'h0;

  counter_hex_input #(.DEBOUNCE_CYCLES(4), .RESET_VALUE(4'h0)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_key_n(i_key_n), .i_down(i_down),
    .i_load(i_load), .i_load_value(i_load_value),
    .o_count(o_count), .o_step(o_step), .o_wrap(o_wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: any count change or pulse is an output event and must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && (o_count !== prev_cnt || o_step === 1'b1 || o_wrap === 1'b1)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: count=%0h step=%b wrap=%b at cycle %0d, none expected",
                   o_count, o_step, o_wrap, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_count", int'(o_count), int'(e.cnt));
          chk("event_step", int'(o_step), int'(e.step));
          chk("event_wrap", int'(o_wrap), int'(e.wrap));
        end
      end
      prev_cnt = o_count;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: step lands on the 6th edge after the first edge sampling low.
  task automatic press(input logic [3:0] val, input logic wrap, input int hold);
    int c;
    c = cyc;
    i_key_n = 1'b0;
    exp_q.push_back('{c + 7, val, 1'b1, wrap});
    idle(hold);
  endtask

  task automatic release_clean();
    i_key_n = 1'b1;
    idle(10);
  endtask

  task automatic load(input logic [3:0] val);
    int c;
    c = cyc;
    i_load = 1'b1;
    i_load_value = val;
    exp_q.push_back('{c + 1, val, 1'b0, 1'b0});
    idle(1);
    i_load = 1'b0;
    idle(3);
  endtask

  initial begin
    int c;
    i_reset = 1'b1; i_key_n = 1'b1; i_down = 1'b0; i_load = 1'b0; i_load_value = 4'h0;
    idle(3);
    chk("reset_count", int'(o_count), 0);
    chk("reset_step", int'(o_step), 0);
    chk("reset_wrap", int'(o_wrap), 0);
    i_reset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    press(4'h1, 1'b0, 20);
    release_clean();

    for (int i = 0; i < 12; i++) begin
      i_key_n = ((i % 4) < 2) ? 1'b0 : 1'b1;
      idle(1);
    end
    press(4'h2, 1'b0, 10);
    for (int i = 0; i < 12; i++) begin
      i_key_n = ((i % 6) < 3) ? 1'b1 : 1'b0;
      idle(1);
    end
    i_key_n = 1'b1;
    idle(12);

    load(4'hF);
    press(4'h0, 1'b1, 10);
    release_clean();

    i_down = 1'b1;
    press(4'hF, 1'b1, 10);
    release_clean();
    press(4'hE, 1'b0, 10);
    release_clean();
    i_down = 1'b0;

    // Load lands exactly on the step edge; the step must vanish.
    c = cyc;
    i_key_n = 1'b0;
    exp_q.push_back('{c + 7, 4'hA, 1'b0, 1'b0});
    idle(6);
    i_load = 1'b1;
    i_load_value = 4'hA;
    idle(1);
    i_load = 1'b0;
    idle(10);
    release_clean();

    // Reset while the debounce counter holds 3, key kept low throughout.
    c = cyc;
    i_key_n = 1'b0;
    idle(5);
    i_reset = 1'b1;
    exp_q.push_back('{c + 6, 4'h0, 1'b0, 1'b0});
    idle(1);
    i_reset = 1'b0;
    exp_q.push_back('{c + 13, 4'h1, 1'b1, 1'b0});
    idle(12);
    release_clean();

    idle(5);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_hex_input.md
COUNTER_HEX_INPUT -- requirements
Module: counter_hex_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable cycles needed before a key level is accepted (minimum 2).
REQ-002 SHALL have parameter RESET_VALUE, default 4'h0, meaning the o_count value after reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: i_clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port: i_reset  input  1  synchronous, active-high reset.
REQ-006 Port: i_key_n  input  1  raw, asynchronous, bouncing push button; active-low (0 = pressed).
REQ-007 Port: i_down  input  1  step direction (0 = increment, 1 = decrement); sampled on the step cycle.
REQ-008 Port: i_load  input  1  synchronous load strobe (level, sampled every cycle).
REQ-009 Port: i_load_value  input  4  value loaded when i_load = 1 (switch bits SW3-SW0).
REQ-010 Port: o_count  output  4  current hex digit; feeds the seven-segment decoder's i_binary_number directly.
REQ-011 Port: o_step  output  1  one-cycle pulse in the cycle o_count first shows a stepped value.
REQ-012 Port: o_wrap  output  1  one-cycle pulse coincident with o_step when the step wrapped (F->0 up, 0->F down).

Function
REQ-013 SHALL pass i_key_n through a two-flop synchronizer before any other use; the synchronizer flops reset to 1 (released).
REQ-014 SHALL hold an accepted key level (reset 1) and a debounce counter wide enough for DEBOUNCE_CYCLES.
- Counter clears whenever the synchronized level equals the accepted level.
- Counter increments each cycle the two levels differ.
- Accepted level toggles, and the counter clears, on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-015 SHALL implement the FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, reset to RELEASED.
- RELEASED->PRESS_WAIT on synchronized 0.
- PRESS_WAIT->RELEASED on synchronized 1 before acceptance.
- PRESS_WAIT->PRESSED on acceptance.
- PRESSED->RELEASE_WAIT on synchronized 1.
- RELEASE_WAIT->PRESSED on synchronized 0 before acceptance.
- RELEASE_WAIT->RELEASED on acceptance.
REQ-016 SHALL generate exactly one step per PRESS_WAIT->PRESSED transition, and none on release or while held.
REQ-017 SHALL update o_count on the step edge, DEBOUNCE_CYCLES+2 rising edges after the first edge that samples i_key_n = 0, provided i_key_n stays 0 throughout.
REQ-018 SHALL compute step arithmetic modulo 16: up gives o_count+1, down gives o_count-1.
REQ-019 SHALL assert o_wrap only for F->0 (up) or 0->F (down).
REQ-020 SHALL give i_load priority over a simultaneous step: o_count <= i_load_value, with no o_step and no o_wrap; the step is discarded, not deferred.
REQ-021 SHALL keep the FSM and debouncer running while i_load is asserted.
REQ-022 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-023 SHALL, in the cycle after i_reset is sampled 1, have these values:
- o_count = RESET_VALUE, o_step = 0, o_wrap = 0.
- FSM = RELEASED, debounce counter = 0, accepted level = 1, synchronizer flops = 1.
REQ-024 SHALL give i_reset priority over i_load and over a step in the same cycle.
REQ-025 SHALL treat a key held through deassertion of reset as a new press: it steps DEBOUNCE_CYCLES+2 edges after reset deasserts.

Verification (DEBOUNCE_CYCLES = 4, RESET_VALUE = 0)
REQ-026 Clean press: i_key_n 1->0 held 20 cycles, i_down = 0 -> o_count 0->1 exactly 6 edges after the first low sample; o_step high for 1 cycle; o_wrap = 0; no further change while held or on release.
REQ-027 Bounce: i_key_n toggles 0/1 every 2 cycles for 12 cycles, then steady 0 -> exactly one step, occurring 6 edges after the start of the steady 0; release with 3-cycle glitches -> no step.
REQ-028 Wrap both ways:
- Load F, press with i_down = 0 -> o_count = 0, o_step = o_wrap = 1 for one cycle.
- Press with i_down = 1 -> o_count = F, o_wrap = 1.
REQ-029 Load collision: i_load = 1, i_load_value = 4'hA in the same cycle a step is due -> o_count = A, o_step = 0; o_count stays A after the key is released.
REQ-030 Reset mid-operation: reset in PRESS_WAIT with debounce counter = 3 -> next cycle o_count = 0 and outputs 0; key still held -> step to 1 occurs 6 edges after reset deasserts.
